// File: rtl/pc_sequencer.sv
// Control-flow sequencer for the ProgramCounter: jumps, branches, call/return
// through a return-address stack, stall and halt (both done by reloading Pc).
module pc_sequencer #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned SW = $clog2(DEPTH + 1)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [15:0]   Pc,
    input  logic          CmdValid,
    input  logic [2:0]    CmdOp,
    input  logic [15:0]   CmdTarget,
    input  logic [8:0]    CmdOffset,
    input  logic          CondFlag,
    input  logic          Stall,
    input  logic          Resume,
    output logic          CmdReady,
    output logic          LoadEnable,
    output logic [15:0]   LoadValue,
    output logic          OffsetEnable,
    output logic [8:0]    Offset,
    output logic [SW-1:0] StackCount,
    output logic          Halted,
    output logic          Fault
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_BR   = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;
    localparam logic [2:0] OP_HALT = 3'd5;

    typedef enum logic [1:0] {RUN, FLUSH, HALTED, FAULT} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   stack [DEPTH];
    logic [SW-1:0] count;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [15:0]   top;

    assign full       = (count == SW'(DEPTH));
    assign empty      = (count == '0);
    assign top        = stack[AW'(count - SW'(1))];
    assign StackCount = count;
    assign Halted     = (state == HALTED);
    assign Fault      = (state == FAULT);

    // State and stack pointer
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= RUN;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (push)
                count <= count + SW'(1);
            else if (pop)
                count <= count - SW'(1);
        end
    end

    // Stack storage needs no reset: entries above count are never read
    always_ff @(posedge Clock) begin
        if (!Reset && push)
            stack[AW'(count)] <= Pc + 16'd1;
    end

    // Zero-latency PC controls and next-state decision
    always_comb begin
        CmdReady     = 1'b0;
        LoadEnable   = 1'b0;
        LoadValue    = '0;
        OffsetEnable = 1'b0;
        Offset       = '0;
        push         = 1'b0;
        pop          = 1'b0;
        state_nxt    = state;
        if (!Reset) begin
            case (state)
                RUN: begin
                    CmdReady = ~Stall;
                    if (Stall) begin
                        LoadEnable = 1'b1;
                        LoadValue  = Pc;
                    end else if (CmdValid) begin
                        case (CmdOp)
                            OP_JMP: begin
                                LoadEnable = 1'b1;
                                LoadValue  = CmdTarget;
                                state_nxt  = FLUSH;
                            end
                            OP_BR: begin
                                if (CondFlag) begin
                                    OffsetEnable = 1'b1;
                                    Offset       = CmdOffset;
                                    state_nxt    = FLUSH;
                                end
                            end
                            OP_CALL: begin
                                LoadEnable = 1'b1;
                                if (full) begin
                                    LoadValue = Pc;
                                    state_nxt = FAULT;
                                end else begin
                                    push      = 1'b1;
                                    LoadValue = CmdTarget;
                                    state_nxt = FLUSH;
                                end
                            end
                            OP_RET: begin
                                LoadEnable = 1'b1;
                                if (empty) begin
                                    LoadValue = Pc;
                                    state_nxt = FAULT;
                                end else begin
                                    pop       = 1'b1;
                                    LoadValue = top;
                                    state_nxt = FLUSH;
                                end
                            end
                            OP_HALT: begin
                                LoadEnable = 1'b1;
                                LoadValue  = Pc;
                                state_nxt  = HALTED;
                            end
                            default: ;
                        endcase
                    end
                end
                FLUSH: begin
                    if (Stall) begin
                        LoadEnable = 1'b1;
                        LoadValue  = Pc;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                HALTED: begin
                    LoadEnable = 1'b1;
                    LoadValue  = Pc;
                    if (Resume)
                        state_nxt = RUN;
                end
                default: begin
                    LoadEnable = 1'b1;
                    LoadValue  = Pc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, multi-cycle
// fault/reset sequences, and randomized traffic against a behavioural model.
module tb_pc_sequencer;

    localparam int DEPTH = 8;
    localparam int SW    = $clog2(DEPTH + 1);

    localparam logic [2:0] NOP = 3'd0, JMP = 3'd1, BR = 3'd2, CALL = 3'd3,
                           RET = 3'd4, HALT = 3'd5;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic [15:0]   Pc;
    logic          CmdValid = 1'b0;
    logic [2:0]    CmdOp = '0;
    logic [15:0]   CmdTarget = '0;
    logic [8:0]    CmdOffset = '0;
    logic          CondFlag = 1'b0;
    logic          Stall = 1'b0;
    logic          Resume = 1'b0;
    logic          CmdReady;
    logic          LoadEnable;
    logic [15:0]   LoadValue;
    logic          OffsetEnable;
    logic [8:0]    Offset;
    logic [SW-1:0] StackCount;
    logic          Halted;
    logic          Fault;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.DEPTH(DEPTH)) dut (
        .Clock(Clock), .Reset(Reset), .Pc(Pc),
        .CmdValid(CmdValid), .CmdOp(CmdOp), .CmdTarget(CmdTarget),
        .CmdOffset(CmdOffset), .CondFlag(CondFlag), .Stall(Stall), .Resume(Resume),
        .CmdReady(CmdReady), .LoadEnable(LoadEnable), .LoadValue(LoadValue),
        .OffsetEnable(OffsetEnable), .Offset(Offset), .StackCount(StackCount),
        .Halted(Halted), .Fault(Fault)
    );

    always #5 Clock = ~Clock;

    // The program counter this block steers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)             Pc <= '0;
        else if (LoadEnable)   Pc <= LoadValue;
        else if (OffsetEnable) Pc <= Pc + {{7{Offset[8]}}, Offset};
        else                   Pc <= Pc + 16'd1;
    end

    typedef struct {
        logic        valid;
        logic [2:0]  op;
        logic [15:0] tgt;
        logic [8:0]  off;
        logic        cond, stall, resume;
        logic        ready, le;
        logic [15:0] lv;
        logic        oe;
        logic [8:0]  offo;
        logic [15:0] pc;
        int          cnt;
        logic        halt, fault;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] t,
                         input logic [8:0] o, input logic c, input logic s, input logic r);
        CmdValid = v; CmdOp = op; CmdTarget = t; CmdOffset = o;
        CondFlag = c; Stall = s; Resume = r;
    endtask

    function automatic vec_t mk(logic v, logic [2:0] op, logic [15:0] t, logic [8:0] o,
                                logic c, logic s, logic r, logic rdy, logic le,
                                logic [15:0] lv, logic oe, logic [8:0] offo,
                                logic [15:0] pc, int cnt, logic h, logic f);
        vec_t x;
        x.valid = v; x.op = op; x.tgt = t; x.off = o; x.cond = c; x.stall = s;
        x.resume = r; x.ready = rdy; x.le = le; x.lv = lv; x.oe = oe; x.offo = offo;
        x.pc = pc; x.cnt = cnt; x.halt = h; x.fault = f;
        return x;
    endfunction

    // Called just after a falling edge; returns just after the next falling edge
    task automatic apply(input vec_t x, input string nm);
        drive(x.valid, x.op, x.tgt, x.off, x.cond, x.stall, x.resume);
        #1;
        chk({nm, " CmdReady"},     32'(CmdReady),     32'(x.ready));
        chk({nm, " LoadEnable"},   32'(LoadEnable),   32'(x.le));
        chk({nm, " LoadValue"},    32'(LoadValue),    32'(x.lv));
        chk({nm, " OffsetEnable"}, 32'(OffsetEnable), 32'(x.oe));
        chk({nm, " Offset"},       32'(Offset),       32'(x.offo));
        @(posedge Clock); #1;
        chk({nm, " Pc"},         32'(Pc),         32'(x.pc));
        chk({nm, " StackCount"}, 32'(StackCount), 32'(x.cnt));
        chk({nm, " Halted"},     32'(Halted),     32'(x.halt));
        chk({nm, " Fault"},      32'(Fault),      32'(x.fault));
        @(negedge Clock);
    endtask

    task automatic do_reset(input string nm);
        Reset = 1'b1;
        drive(1'b1, JMP, 16'h1234, 9'h0AA, 1'b1, 1'b0, 1'b1);
        #1;
        chk({nm, " rst CmdReady"},     32'(CmdReady),     0);
        chk({nm, " rst LoadEnable"},   32'(LoadEnable),   0);
        chk({nm, " rst LoadValue"},    32'(LoadValue),    0);
        chk({nm, " rst OffsetEnable"}, 32'(OffsetEnable), 0);
        chk({nm, " rst Offset"},       32'(Offset),       0);
        @(posedge Clock); #1;
        chk({nm, " rst StackCount"}, 32'(StackCount), 0);
        chk({nm, " rst Halted"},     32'(Halted),     0);
        chk({nm, " rst Fault"},      32'(Fault),      0);
        @(negedge Clock);
        Reset = 1'b0;
        drive(1'b0, NOP, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reference model state
    typedef enum int {M_RUN, M_FLUSH, M_HALTED, M_FAULT} mmode_t;
    mmode_t      mmode;
    logic [15:0] mstk[$];

    initial begin
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        chk("reset StackCount", 32'(StackCount), 0);
        chk("reset Halted", 32'(Halted), 0);
        chk("reset Fault", 32'(Fault), 0);

        // valid op tgt off cond stall resume | ready le lv oe offo | pc cnt halt fault
        vecs.push_back(mk(0, NOP, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  16'h0001, 0, 0, 0));
        vecs.push_back(mk(0, NOP, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  16'h0002, 0, 0, 0));
        vecs.push_back(mk(0, NOP, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  16'h0003, 0, 0, 0));
        vecs.push_back(mk(1, JMP, 16'h000F, 0, 0, 0, 0,  1, 1, 16'h000F, 0, 0,  16'h000F, 0, 0, 0));
        vecs.push_back(mk(0, NOP, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  16'h0010, 0, 0, 0));
        vecs.push_back(mk(1, JMP, 16'h0200, 0, 0, 0, 0,  1, 1, 16'h0200, 0, 0,  16'h0200, 0, 0, 0));
        vecs.push_back(mk(1, JMP, 16'h0999, 0, 0, 0, 0,  0, 0, 0, 0, 0,  16'h0201, 0, 0, 0));
        vecs.push_back(mk(1, NOP, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  16'h0202, 0, 0, 0));
        vecs.push_back(mk(1, JMP, 16'h003F, 0, 0, 0, 0,  1, 1, 16'h003F, 0, 0,  16'h003F, 0, 0, 0));
        vecs.push_back(mk(0, NOP, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  16'h0040, 0, 0, 0));
        vecs.push_back(mk(1, BR, 0, 9'h1F0, 1, 0, 0,  1, 0, 0, 1, 9'h1F0,  16'h0030, 0, 0, 0));
        vecs.push_back(mk(0, NOP, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  16'h0031, 0, 0, 0));
        vecs.push_back(mk(1, BR, 0, 9'h1F0, 0, 0, 0,  1, 0, 0, 0, 0,  16'h0032, 0, 0, 0));
        vecs.push_back(mk(1, JMP, 16'h00FF, 0, 0, 0, 0,  1, 1, 16'h00FF, 0, 0,  16'h00FF, 0, 0, 0));
        vecs.push_back(mk(0, NOP, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  16'h0100, 0, 0, 0));
        vecs.push_back(mk(1, CALL, 16'h0800, 0, 0, 0, 0,  1, 1, 16'h0800, 0, 0,  16'h0800, 1, 0, 0));
        vecs.push_back(mk(0, NOP, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  16'h0801, 1, 0, 0));
        vecs.push_back(mk(1, RET, 16'h0777, 0, 0, 0, 0,  1, 1, 16'h0101, 0, 0,  16'h0101, 0, 0, 0));
        vecs.push_back(mk(0, NOP, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  16'h0102, 0, 0, 0));
        vecs.push_back(mk(1, JMP, 16'hFFFE, 0, 0, 0, 0,  1, 1, 16'hFFFE, 0, 0,  16'hFFFE, 0, 0, 0));
        vecs.push_back(mk(0, NOP, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  16'hFFFF, 0, 0, 0));
        vecs.push_back(mk(1, CALL, 16'h1234, 0, 0, 0, 0,  1, 1, 16'h1234, 0, 0,  16'h1234, 1, 0, 0));
        vecs.push_back(mk(0, NOP, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  16'h1235, 1, 0, 0));
        vecs.push_back(mk(1, RET, 0, 0, 0, 0, 0,  1, 1, 16'h0000, 0, 0,  16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, NOP, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  16'h0001, 0, 0, 0));
        vecs.push_back(mk(1, JMP, 16'h0500, 0, 0, 1, 0,  0, 1, 16'h0001, 0, 0,  16'h0001, 0, 0, 0));
        vecs.push_back(mk(1, JMP, 16'h0500, 0, 0, 0, 0,  1, 1, 16'h0500, 0, 0,  16'h0500, 0, 0, 0));
        vecs.push_back(mk(0, NOP, 0, 0, 0, 1, 0,  0, 1, 16'h0500, 0, 0,  16'h0500, 0, 0, 0));
        vecs.push_back(mk(0, NOP, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  16'h0501, 0, 0, 0));
        vecs.push_back(mk(1, 3'd6, 16'h0AAA, 0, 0, 0, 0,  1, 0, 0, 0, 0,  16'h0502, 0, 0, 0));
        vecs.push_back(mk(1, JMP, 16'h0054, 0, 0, 0, 0,  1, 1, 16'h0054, 0, 0,  16'h0054, 0, 0, 0));
        vecs.push_back(mk(0, NOP, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  16'h0055, 0, 0, 0));
        vecs.push_back(mk(1, HALT, 0, 0, 0, 0, 0,  1, 1, 16'h0055, 0, 0,  16'h0055, 0, 1, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, JMP, 16'h0700, 0, 0, 0, 0,  0, 1, 16'h0055, 0, 0,  16'h0055, 0, 1, 0));
        vecs.push_back(mk(0, NOP, 0, 0, 0, 1, 1,  0, 1, 16'h0055, 0, 0,  16'h0055, 0, 0, 0));
        vecs.push_back(mk(0, NOP, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  16'h0056, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("v%0d", i));

        // Overflow: eight CALLs fill the stack, the ninth faults
        do_reset("ovf");
        for (int i = 0; i < DEPTH; i++) begin
            logic [15:0] t;
            t = 16'((i + 1) * 16'h0100);
            apply(mk(1, CALL, t, 0, 0, 0, 0,  1, 1, t, 0, 0,  t, i + 1, 0, 0), $sformatf("call%0d", i));
            apply(mk(0, NOP, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  t + 16'd1, i + 1, 0, 0), $sformatf("cfl%0d", i));
        end
        apply(mk(1, CALL, 16'h0900, 0, 0, 0, 0,  1, 1, 16'h0801, 0, 0,  16'h0801, DEPTH, 0, 1), "call9");
        for (int i = 0; i < 3; i++)
            apply(mk(1, RET, 0, 0, 0, 0, 1,  0, 1, 16'h0801, 0, 0,  16'h0801, DEPTH, 0, 1), $sformatf("flt%0d", i));

        // Reset discards the stack: a RET after release underflows
        do_reset("clr");
        apply(mk(1, CALL, 16'h0040, 0, 0, 0, 0,  1, 1, 16'h0040, 0, 0,  16'h0040, 1, 0, 0), "rcall");
        apply(mk(0, NOP, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  16'h0041, 1, 0, 0), "rflush");
        do_reset("mid");
        apply(mk(1, RET, 0, 0, 0, 0, 0,  1, 1, 16'h0000, 0, 0,  16'h0000, 0, 0, 1), "uret");
        apply(mk(1, JMP, 16'h0300, 0, 0, 0, 1,  0, 1, 16'h0000, 0, 0,  16'h0000, 0, 0, 1), "uhold");

        // Randomized traffic against the model
        do_reset("rnd");
        mmode = M_RUN;
        mstk.delete();
        for (int n = 0; n < 4000; n++) begin
            logic v, c, s, r, e_rdy, e_le, e_oe;
            logic [2:0] op;
            logic [15:0] t, e_lv;
            logic [8:0] o, e_off;
            mmode_t nm;
            int k;
            if ($urandom_range(0, 299) == 0 || (mmode == M_FAULT && $urandom_range(0, 7) == 0)) begin
                do_reset($sformatf("r%0d", n));
                mmode = M_RUN;
                mstk.delete();
                continue;
            end
            v = ($urandom_range(0, 9) < 7);
            k = $urandom_range(0, 15);
            op = (k < 3) ? JMP : (k < 6) ? BR : (k < 10) ? CALL : (k < 13) ? RET :
                 (k == 13) ? HALT : (k == 14) ? NOP : 3'(6 + $urandom_range(0, 1));
            t = 16'($urandom);
            o = 9'($urandom);
            c = 1'($urandom);
            s = ($urandom_range(0, 4) == 0);
            r = ($urandom_range(0, 2) == 0);

            e_rdy = 0; e_le = 0; e_lv = 0; e_oe = 0; e_off = 0; nm = mmode;
            if (mmode == M_RUN && !s) begin
                e_rdy = 1;
                if (v && op == JMP) begin
                    e_le = 1; e_lv = t; nm = M_FLUSH;
                end else if (v && op == BR && c) begin
                    e_oe = 1; e_off = o; nm = M_FLUSH;
                end else if (v && op == CALL) begin
                    e_le = 1;
                    if (mstk.size() == DEPTH) begin e_lv = Pc; nm = M_FAULT; end
                    else begin mstk.push_back(Pc + 16'd1); e_lv = t; nm = M_FLUSH; end
                end else if (v && op == RET) begin
                    e_le = 1;
                    if (mstk.size() == 0) begin e_lv = Pc; nm = M_FAULT; end
                    else begin e_lv = mstk.pop_back(); nm = M_FLUSH; end
                end else if (v && op == HALT) begin
                    e_le = 1; e_lv = Pc; nm = M_HALTED;
                end
            end else if (mmode == M_FLUSH && !s) begin
                nm = M_RUN;
            end else begin
                e_le = 1; e_lv = Pc;
                if (mmode == M_HALTED && r) nm = M_RUN;
            end

            apply(mk(v, op, t, o, c, s, r,  e_rdy, e_le, e_lv, e_oe, e_off,
                     e_le ? e_lv : e_oe ? Pc + {{7{o[8]}}, o} : Pc + 16'd1,
                     mstk.size(), nm == M_HALTED, nm == M_FAULT), $sformatf("rnd%0d", n));
            mmode = nm;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
